// File: rtl/dmem_pkg.sv
// Shared types, FUNCT3 codes and access-size helpers for the data_memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dmem_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

  // Reserved FUNCT3 codes behave as full-word accesses.
  function automatic dmem_size_e f3_size(input logic [2:0] funct3);
    dmem_size_e size;
    case (funct3)
      F3_B, F3_BU: size = SZ_B;
      F3_H, F3_HU: size = SZ_H;
      F3_W:        size = SZ_W;
      default:     size = SZ_W;
    endcase
    return size;
  endfunction

  function automatic logic f3_signed(input logic [2:0] funct3);
    return ~funct3[2];
  endfunction

  function automatic logic is_misaligned(input dmem_size_e size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [1:0] align_lo(input dmem_size_e size, input logic [1:0] lo);
    logic [1:0] aligned;
    case (size)
      SZ_B:    aligned = lo;
      SZ_H:    aligned = {lo[1], 1'b0};
      default: aligned = 2'b00;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and store
// byte-enable generation with lane-replicated write data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] st_word_o
);

  dmem_size_e size_s;
  logic       sext_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign size_s = f3_size(funct3_i);
  assign sext_s = f3_signed(funct3_i);

  // Load path: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    byte_s    = 8'h00;
    half_s    = 16'h0000;
    ld_data_o = rd_word_i;
    case (addr_lo_i)
      2'd0:    byte_s = rd_word_i[7:0];
      2'd1:    byte_s = rd_word_i[15:8];
      2'd2:    byte_s = rd_word_i[23:16];
      2'd3:    byte_s = rd_word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = rd_word_i[31:16];
    end else begin
      half_s = rd_word_i[15:0];
    end
    case (size_s)
      SZ_B:    ld_data_o = {{24{sext_s & byte_s[7]}}, byte_s};
      SZ_H:    ld_data_o = {{16{sext_s & half_s[15]}}, half_s};
      default: ld_data_o = rd_word_i;
    endcase
  end

  // Store path: replicate the low bytes across lanes so the enable alone picks the target.
  always_comb begin
    byte_en_o = 4'hF;
    st_word_o = st_data_i;
    case (size_s)
      SZ_B: begin
        byte_en_o = 4'b0001 << addr_lo_i;
        st_word_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        if (addr_lo_i[1]) begin
          byte_en_o = 4'b1100;
        end else begin
          byte_en_o = 4'b0011;
        end
        st_word_o = {2{st_data_i[15:0]}};
      end
      default: begin
        byte_en_o = 4'hF;
        st_word_o = st_data_i;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data memory for the RV32IM MEM stage with a BUSYWAIT stall handshake and
// fixed access latency. Define DMEM_MISALIGN_CHECK_EN to flag misaligned H/W accesses.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  input  logic [2:0]  FUNCT3,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  dmem_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          wr_q;
  logic [31:0]   rdata_q;
  logic          mis_q;
  logic [31:0]   mem_q [DEPTH];

  logic          req_s;
  logic          access_s;
  logic          bad_s;
  dmem_size_e    size_s;
  logic [1:0]    lo_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   ld_data_s;
  logic [31:0]   st_word_s;
  logic [3:0]    byte_en_s;
  logic [31:0]   wr_word_d;
  logic          unused_s;

  assign req_s     = MEM_READ | MEM_WRITE;
  assign access_s  = (state_q == ACCESS) && (cnt_q == '0);
  assign size_s    = f3_size(f3_q);
  assign idx_s     = addr_q[AW+1:2];
  assign rd_word_s = mem_q[idx_s];
  assign unused_s  = ^MEM_ADDRESS[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign lo_s  = addr_q[1:0];
  assign bad_s = is_misaligned(size_s, addr_q[1:0]);
`else
  assign lo_s  = align_lo(size_s, addr_q[1:0]);
  assign bad_s = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .rd_word_i (rd_word_s),
    .addr_lo_i (lo_s),
    .funct3_i  (f3_q),
    .st_data_i (wdata_q),
    .ld_data_o (ld_data_s),
    .byte_en_o (byte_en_s),
    .st_word_o (st_word_s)
  );

  // Read-modify-write merge: only enabled lanes take the new store data.
  always_comb begin
    wr_word_d = rd_word_s;
    for (int b = 0; b < 4; b++) begin
      wr_word_d[8*b +: 8] = byte_en_s[b] ? st_word_s[8*b +: 8] : rd_word_s[8*b +: 8];
    end
  end

  // Request FSM; the request is latched in IDLE so later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      f3_q    <= 3'b000;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0000_0000;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_s) begin
            addr_q  <= MEM_ADDRESS[AW+1:0];
            wdata_q <= MEM_WRITE_DATA;
            f3_q    <= FUNCT3;
            wr_q    <= MEM_WRITE;
            cnt_q   <= CNT_INIT;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            mis_q   <= bad_s;
            if (!wr_q) begin
              rdata_q <= bad_s ? 32'h0000_0000 : ld_data_s;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage array: cleared by reset, store commits on the final ACCESS edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (access_s && wr_q && !bad_s) begin
      mem_q[idx_s] <= wr_word_d;
    end
  end

  assign BUSYWAIT   = ((state_q == IDLE) && req_s) || (state_q == ACCESS);
  assign READ_DATA  = rdata_q;
  assign MISALIGNED = mis_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// transactions compared against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int NBYTES  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic        busywait;
  logic        misaligned;

  int npass  = 0;
  int ntotal = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] ref_rd;

  data_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK            (clk),
    .RESET          (reset),
    .MEM_READ       (mem_read),
    .MEM_WRITE      (mem_write),
    .MEM_ADDRESS    (mem_address),
    .MEM_WRITE_DATA (mem_write_data),
    .FUNCT3         (funct3),
    .READ_DATA      (read_data),
    .BUSYWAIT       (busywait),
    .MISALIGNED     (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [31:0] addr, input logic [2:0] f3);
`ifdef DMEM_MISALIGN_CHECK_EN
    return (int'(addr % 32'd4) % acc_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_base(input logic [31:0] addr, input logic [2:0] f3);
    int a;
    a = int'(addr % NBYTES);
    return a - (a % acc_size(f3));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int n;
    int a;
    logic [31:0] v;
    n = acc_size(f3);
    a = ref_base(addr, f3);
    v = 32'd0;
    if (ref_mis(addr, f3)) return 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (f3 == 3'b000 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    ref_rd = 32'd0;
  endtask

  task automatic model_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3);
    int n;
    int a;
    n = acc_size(f3);
    a = ref_base(addr, f3);
    if (wr) begin
      if (!ref_mis(addr, f3))
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'((data >> (8 * k)) & 32'hFF);
    end else if (rd) begin
      ref_rd = ref_load(addr, f3);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic apply_reset();
    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'd0;
    mem_write_data = 32'd0;
    funct3 = 3'b010;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Drives one request and reports what was observed; callers do the comparisons.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3, input logic scr,
                        output int lat, output logic [31:0] rdata, output logic mis,
                        output logic mis_after, output logic busy_after);
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_write_data = data;
    funct3 = f3;
    #1;
    lat = 0;
    while (busywait === 1'b1 && lat < 50) begin
      lat++;
      @(negedge clk);
      if (scr && lat == 1) begin
        mem_address = $urandom;
        mem_write_data = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
    end
    rdata = read_data;
    mis = misaligned;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    mis_after = misaligned;
    busy_after = busywait;
  endtask

  int lat;
  logic [31:0] rdata;
  logic mis, mis_after, busy_after;

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    ntotal++;
    if (read_data !== 32'd0) $display("FAIL reset_read_data: got %h want 00000000", read_data);
    else npass++;
    ntotal++;
    if (busywait !== 1'b0) $display("FAIL reset_busywait: got %b want 0", busywait);
    else npass++;
    ntotal++;
    if (misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b want 0", misaligned);
    else npass++;
  endtask

  task automatic test_first_load();
    do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    ntotal++;
    if (lat !== LATENCY + 1) $display("FAIL first_lw_latency: got %0d want %0d", lat, LATENCY + 1);
    else npass++;
    ntotal++;
    if (rdata !== 32'd0) $display("FAIL first_lw_data: got %h want 00000000", rdata);
    else npass++;
    ntotal++;
    if (busy_after !== 1'b0) $display("FAIL first_lw_idle_busy: got %b want 0", busy_after);
    else npass++;
  endtask

  task automatic test_lane_loads();
    logic [31:0] addrs [4] = '{32'h21, 32'h23, 32'h22, 32'h22};
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [4] = '{32'h0000_0023, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_80F1};
    do_req(1'b0, 1'b1, 32'h20, 32'h80F1_2345, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h20, 32'h80F1_2345, 3'b010);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 1'b0, addrs[i], 32'd0, f3s[i], 1'b0, lat, rdata, mis, mis_after, busy_after);
      model_txn(1'b1, 1'b0, addrs[i], 32'd0, f3s[i]);
      ntotal++;
      if (rdata !== exps[i]) $display("FAIL lane_load_%0d: got %h want %h", i, rdata, exps[i]);
      else npass++;
    end
  endtask

  task automatic test_store_merge();
    do_req(1'b0, 1'b1, 32'h24, 32'h1122_3344, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h24, 32'h1122_3344, 3'b010);
    do_req(1'b0, 1'b1, 32'h25, 32'h5555_55AA, 3'b000, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h25, 32'h5555_55AA, 3'b000);
    do_req(1'b1, 1'b0, 32'h24, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h24, 32'd0, 3'b010);
    ntotal++;
    if (rdata !== 32'h1122_AA44) $display("FAIL sb_merge: got %h want 1122aa44", rdata);
    else npass++;
    do_req(1'b0, 1'b1, 32'h26, 32'h7777_BEEF, 3'b001, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h26, 32'h7777_BEEF, 3'b001);
    do_req(1'b1, 1'b0, 32'h24, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h24, 32'd0, 3'b010);
    ntotal++;
    if (rdata !== 32'hBEEF_AA44) $display("FAIL sh_merge: got %h want beefaa44", rdata);
    else npass++;
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 3'b010);
    do_req(1'b1, 1'b0, 32'h000, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h000, 32'd0, 3'b010);
    ntotal++;
    if (rdata !== 32'hDEAD_BEEF) $display("FAIL addr_wrap: got %h want deadbeef", rdata);
    else npass++;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    mem_write = 1'b1;
    mem_address = 32'h30;
    mem_write_data = 32'h1234_5678;
    funct3 = 3'b010;
    @(negedge clk);
    @(negedge clk);
    ntotal++;
    if (busywait !== 1'b1) $display("FAIL abort_in_access_busy: got %b want 1", busywait);
    else npass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_write = 1'b0;
    model_clear();
    @(negedge clk);
    ntotal++;
    if (busywait !== 1'b0) $display("FAIL abort_busy_after: got %b want 0", busywait);
    else npass++;
    do_req(1'b1, 1'b0, 32'h30, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h30, 32'd0, 3'b010);
    ntotal++;
    if (rdata !== 32'd0) $display("FAIL abort_no_commit: got %h want 00000000", rdata);
    else npass++;
  endtask

  task automatic test_misalign();
    logic [31:0] exp_rd;
    logic exp_mis;
    logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_rd = 32'd0;
    exp_mis = 1'b1;
    exp_word = 32'hCAFE_F00D;
`else
    exp_rd = 32'hCAFE_F00D;
    exp_mis = 1'b0;
    exp_word = 32'h1234_F00D;
`endif
    do_req(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 3'b010);
    do_req(1'b1, 1'b0, 32'h31, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h31, 32'd0, 3'b010);
    ntotal++;
    if (lat !== LATENCY + 1) $display("FAIL misalign_latency: got %0d want %0d", lat, LATENCY + 1);
    else npass++;
    ntotal++;
    if (mis !== exp_mis) $display("FAIL misalign_flag: got %b want %b", mis, exp_mis);
    else npass++;
    ntotal++;
    if (mis_after !== 1'b0) $display("FAIL misalign_pulse_width: got %b want 0", mis_after);
    else npass++;
    ntotal++;
    if (rdata !== exp_rd) $display("FAIL misalign_lw_data: got %h want %h", rdata, exp_rd);
    else npass++;
    do_req(1'b0, 1'b1, 32'h33, 32'h0000_1234, 3'b001, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h33, 32'h0000_1234, 3'b001);
    ntotal++;
    if (mis !== exp_mis) $display("FAIL misalign_sh_flag: got %b want %b", mis, exp_mis);
    else npass++;
    do_req(1'b1, 1'b0, 32'h30, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h30, 32'd0, 3'b010);
    ntotal++;
    if (rdata !== exp_word) $display("FAIL misalign_sh_effect: got %h want %h", rdata, exp_word);
    else npass++;
  endtask

  task automatic test_both_ops();
    do_req(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 3'b010);
    do_req(1'b1, 1'b0, 32'h40, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h40, 32'd0, 3'b010);
    do_req(1'b1, 1'b1, 32'h40, 32'h1111_1111, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b1, 32'h40, 32'h1111_1111, 3'b010);
    ntotal++;
    if (rdata !== 32'h0BAD_F00D) $display("FAIL both_ops_rd_held: got %h want 0badf00d", rdata);
    else npass++;
    do_req(1'b1, 1'b0, 32'h40, 32'd0, 3'b010, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h40, 32'd0, 3'b010);
    ntotal++;
    if (rdata !== 32'h1111_1111) $display("FAIL both_ops_write: got %h want 11111111", rdata);
    else npass++;
  endtask

  task automatic test_undef_f3();
    do_req(1'b0, 1'b1, 32'h44, 32'h89AB_CDEF, 3'b011, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b0, 1'b1, 32'h44, 32'h89AB_CDEF, 3'b011);
    do_req(1'b1, 1'b0, 32'h44, 32'd0, 3'b110, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h44, 32'd0, 3'b110);
    ntotal++;
    if (rdata !== 32'h89AB_CDEF) $display("FAIL undef_f3_word: got %h want 89abcdef", rdata);
    else npass++;
    do_req(1'b1, 1'b0, 32'h46, 32'd0, 3'b111, 1'b0, lat, rdata, mis, mis_after, busy_after);
    model_txn(1'b1, 1'b0, 32'h46, 32'd0, 3'b111);
    ntotal++;
    if (rdata !== ref_rd) $display("FAIL undef_f3_offset: got %h want %h", rdata, ref_rd);
    else npass++;
  endtask

  task automatic test_random();
    logic rd, wr, exp_mis;
    logic [2:0] f3;
    logic [31:0] addr, data;
    for (int i = 0; i < 200; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      addr = (32'($urandom_range(0, 15)) << 28) | (32'($urandom_range(0, 3)) << 10)
           | 32'($urandom_range(0, 47));
      data = $urandom;
      exp_mis = ref_mis(addr, f3);
      do_req(rd, wr, addr, data, f3, (i % 3) == 0, lat, rdata, mis, mis_after, busy_after);
      model_txn(rd, wr, addr, data, f3);
      ntotal++;
      if (lat !== LATENCY + 1) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LATENCY + 1);
      else npass++;
      ntotal++;
      if (rdata !== ref_rd)
        $display("FAIL rand_read_data[%0d] rd=%b wr=%b f3=%b addr=%h: got %h want %h",
                 i, rd, wr, f3, addr, rdata, ref_rd);
      else npass++;
      ntotal++;
      if (mis !== exp_mis) $display("FAIL rand_misaligned[%0d]: got %b want %b", i, mis, exp_mis);
      else npass++;
      ntotal++;
      if (mis_after !== 1'b0 || busy_after !== 1'b0)
        $display("FAIL rand_idle[%0d]: got mis=%b busy=%b want 0 0", i, mis_after, busy_after);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_lane_loads();
    test_store_merge();
    test_wrap();
    test_reset_abort();
    test_misalign();
    test_both_ops();
    test_undef_f3();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
